instruction_fetch_unit: RTL and testbench

//   Fetch stage feeding the Controller: holds PC, requests words from instruction memory,

---
 rtl/instruction_fetch_unit_if.sv | 10 +
 rtl/instruction_fetch_unit.sv | 110 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, input ack, rdata);
    modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds PC, fetches one word per instruction, decodes fields, steps PC or takes bne.
// Optional instruction counter enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_unit_if.master   imem,
    input  logic                       advance,
    input  logic                       branch_taken,
    input  logic [15:0]                branch_offset,
    output logic                       instr_valid,
    output logic [31:0]                instr,
    output logic [5:0]                 op,
    output logic [5:0]                 func,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [15:0]                imm,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    output logic                       fetch_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                instr_count
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   count, count_d;
    logic [31:0]     pc_d, instr_d, next_pc;

    assign pc_plus4 = pc + 32'd4;
    assign next_pc  = branch_taken
                    ? pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}
                    : pc_plus4;

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            pc    <= PC_INIT;
            instr <= '0;
        end else begin
            state <= state_d;
            count <= count_d;
            pc    <= pc_d;
            instr <= instr_d;
        end
    end

    // NOTE: every target gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state;
        count_d = count;
        pc_d    = pc;
        instr_d = instr;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem.ack) begin
                    instr_d = imem.rdata;
                    count_d = '0;
                    state_d = HOLD;
                end else begin
                    count_d = count + CW'(1);
                    if (count_d == CW'(TIMEOUT)) state_d = ERR;
                end
            end
            HOLD: begin
                if (advance) begin
                    pc_d    = next_pc;
                    state_d = REQ;
                end
            end
            ERR: state_d = ERR;
        endcase
    end

    // Outputs are pure functions of state so reset drops the request immediately.
    assign imem.req    = (state == REQ);
    assign imem.addr   = pc;
    assign instr_valid = (state == HOLD);
    assign fetch_err   = (state == ERR);

    assign op   = instr[31:26];
    assign rs   = instr[25:21];
    assign rt   = instr[20:16];
    assign rd   = instr[15:11];
    assign imm  = instr[15:0];
    assign func = instr[5:0];

`ifdef FETCH_PERF_CNT_EN
    logic adv_accept;
    assign adv_accept = (state == HOLD) && advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          instr_count <= '0;
        else if (adv_accept) instr_count <= instr_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level PC/instruction model.
module tb_instruction_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        advance, branch_taken;
    logic [15:0] branch_offset;
    logic        instr_valid, fetch_err;
    logic [31:0] instr, pc, pc_plus4;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_count;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;

    instruction_fetch_unit_if imem_bus();

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_bus),
        .advance      (advance),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .op           (op),
        .func         (func),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm          (imm),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_err    (fetch_err)
`ifdef FETCH_PERF_CNT_EN
        ,
        .instr_count  (instr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count();
`ifdef FETCH_PERF_CNT_EN
        check("instr_count", instr_count, exp_count);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        advance = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        imem_bus.ack = 1'b0; imem_bus.rdata = '0;
        step(); step();
        check("rst_req", 32'(imem_bus.req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_op", 32'(op), 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        exp_pc = 32'd0;
        exp_count = 32'd0;
        check_count();
        rst_n = 1'b1;
        step();
    endtask

    // One instruction: waits REQ cycles without ack, ack, holds, then advance.
    task automatic fetch_one(input logic [31:0] word, input int waits, input int holds,
                             input logic br, input logic [15:0] off);
        logic signed [31:0] disp;
        check("req_addr", imem_bus.addr, exp_pc);
        check("req_on", 32'(imem_bus.req), 32'd1);
        check("req_valid_low", 32'(instr_valid), 32'd0);
        for (int i = 0; i < waits; i++) begin
            imem_bus.ack = 1'b0; imem_bus.rdata = $urandom;
            advance = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
            step();
            check("wait_req", 32'(imem_bus.req), 32'd1);
            check("wait_addr", imem_bus.addr, exp_pc);
        end
        imem_bus.ack = 1'b1; imem_bus.rdata = word; advance = 1'b0;
        step();
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_req", 32'(imem_bus.req), 32'd0);
        check("instr", instr, word);
        check("op", 32'(op), word >> 26);
        check("rs", 32'(rs), (word >> 21) & 32'h1F);
        check("rt", 32'(rt), (word >> 16) & 32'h1F);
        check("rd", 32'(rd), (word >> 11) & 32'h1F);
        check("func", 32'(func), word & 32'h3F);
        check("imm", 32'(imm), word & 32'hFFFF);
        check("pc", pc, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        for (int i = 0; i < holds; i++) begin
            imem_bus.ack = 1'($urandom_range(0, 1)); imem_bus.rdata = $urandom;
            advance = 1'b0; branch_taken = 1'($urandom_range(0, 1));
            step();
            check("hold_stable", instr, word);
            check("hold_stay", 32'(instr_valid), 32'd1);
        end
        imem_bus.ack = 1'($urandom_range(0, 1)); imem_bus.rdata = $urandom;
        advance = 1'b1; branch_taken = br; branch_offset = off;
        step();
        disp = $signed(off);
        exp_pc = exp_pc + 32'd4 + (br ? 32'(disp * 4) : 32'd0);
        exp_count = exp_count + 32'd1;
        advance = 1'b0; branch_taken = 1'b0; imem_bus.ack = 1'b0;
        check("adv_valid_drop", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        do_reset();

        // Sequential fetch with zero-wait memory, then a backward branch at 0x10.
        fetch_one(32'h012A4020, 0, 0, 1'b0, 16'h0);
        fetch_one($urandom, 0, 0, 1'b0, 16'h0);
        fetch_one($urandom, 0, 0, 1'b0, 16'h0);
        fetch_one($urandom, 0, 0, 1'b0, 16'h0);
        check("seq_pc10", imem_bus.addr, 32'h10);
        fetch_one($urandom, 0, 0, 1'b1, 16'hFFFE);
        check("branch_back", imem_bus.addr, 32'h0C);
        check_count();

        // Known decode vector at PC 0.
        do_reset();
        imem_bus.ack = 1'b1; imem_bus.rdata = 32'h012A4020;
        step();
        check("dec_op", 32'(op), 32'd0);
        check("dec_rs", 32'(rs), 32'd9);
        check("dec_rt", 32'(rt), 32'd10);
        check("dec_rd", 32'(rd), 32'd8);
        check("dec_func", 32'(func), 32'h20);
        check("dec_valid", 32'(instr_valid), 32'd1);
        advance = 1'b1; imem_bus.ack = 1'b0;
        step();
        advance = 1'b0;
        exp_pc = 32'd4; exp_count = 32'd1;

        for (int n = 0; n < 60; n++)
            fetch_one($urandom, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 16'($urandom));
        check_count();

        // Reset asserted in the middle of a request at 0x40.
        do_reset();
        fetch_one($urandom, 0, 0, 1'b1, 16'h000F);
        check("pc40", imem_bus.addr, 32'h40);
        rst_n = 1'b0;
        #1;
        check("rst_drops_req", 32'(imem_bus.req), 32'd0);
        step();
        rst_n = 1'b1;
        check("rst_pc_back", pc, 32'd0);
        step();
        check("rst_refetch", imem_bus.addr, 32'd0);
        check("rst_refetch_req", 32'(imem_bus.req), 32'd1);
        exp_pc = 32'd0; exp_count = 32'd0;

        // Branch to 0xFFFF_FFFC, then PC+4 wraps to zero.
        fetch_one($urandom, 1, 1, 1'b1, 16'hFFFE);
        check("wrap_top", imem_bus.addr, 32'hFFFF_FFFC);
        fetch_one($urandom, 0, 0, 1'b0, 16'h0);
        check("wrap_zero", imem_bus.addr, 32'd0);
        check_count();

        // Memory timeout: TIMEOUT REQ cycles without ack.
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            imem_bus.ack = 1'b0; advance = 1'($urandom_range(0, 1));
            step();
        end
        check("pre_timeout_err", 32'(fetch_err), 32'd0);
        check("pre_timeout_req", 32'(imem_bus.req), 32'd1);
        step();
        check("timeout_err", 32'(fetch_err), 32'd1);
        check("timeout_req", 32'(imem_bus.req), 32'd0);
        check("timeout_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            imem_bus.ack = 1'($urandom_range(0, 1)); advance = 1'($urandom_range(0, 1));
            step();
        end
        check("err_sticky", 32'(fetch_err), 32'd1);
        check("err_no_req", 32'(imem_bus.req), 32'd0);
        check_count();
        rst_n = 1'b0;
        #1;
        check("err_cleared", 32'(fetch_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
